// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_full_adder.sv
// Single-bit full adder cell; the only arithmetic in the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one operand bit per clock, LSB first, through one full adder.
// Subtraction is a + ~b + 1, so the reported carry is inverted to read as a borrow.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_shifted;
  logic             cin_r;
  logic             mode_r;
  logic             fa_sum;
  logic             fa_cout;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (cin_r),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign res_shifted = {fa_sum, res_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST_BIT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are captured at accept so later input changes cannot disturb the operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cin_r  <= 1'b0;
      mode_r <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= (mode == MODE_ADD) ? b : ~b;
            cin_r  <= (mode == MODE_SUB);
            mode_r <= mode;
            cnt    <= '0;
            res_sr <= '0;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_shifted;
          cin_r  <= fa_cout;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            result <= res_shifted;
            carry  <= fa_cout ^ mode_r;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub at WIDTH=4 (directed + exhaustive) and WIDTH=8.
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start4, mode4, busy4, done4, carry4;
  logic [3:0] a4, b4, result4;
  logic       start8, mode8, busy8, done8, carry8;
  logic [7:0] a8, b8, result8;

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] q4[$];
  logic [8:0] q8[$];
  logic [8:0] exp4, exp8;
  logic [3:0] held4;
  int         edges8;
  int         first_done, second_done, done_count;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(result4), .carry(carry4)
  );

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .carry(carry8)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [4:0] model4(input logic m, input logic [3:0] x, input logic [3:0] y);
    logic [3:0] d;
    if (!m) return {1'b0, x} + {1'b0, y};
    d = x - y;
    return {(x < y), d};
  endfunction

  always @(negedge clk) begin
    if (done4) begin
      if (q4.size() == 0) check_output("done4_unexpected", 1, 0);
      else begin
        exp4 = q4.pop_front();
        check_output("res4", {carry4, result4}, exp4);
      end
    end
  end

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) check_output("done8_unexpected", 1, 0);
      else begin
        exp8 = q8.pop_front();
        check_output("res8", {carry8, result8}, exp8);
      end
    end
  end

  // Drives one accepted operation and follows it to its done pulse, checking timing and hold.
  task automatic apply_stimulus(input logic m, input logic [3:0] x, input logic [3:0] y);
    int         edges, busy_cycles;
    bit         seen;
    logic [4:0] e;
    e = model4(m, x, y);
    mode4 = m; a4 = x; b4 = y; start4 = 1'b1;
    q4.push_back({4'b0, e});
    @(posedge clk); #1;
    start4 = 1'b0; mode4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
    edges = 0; busy_cycles = 0; seen = 0;
    while (!seen && edges < 12) begin
      if (busy4) busy_cycles++;
      if (busy4 && done4) check_output("busy_done_overlap", 1, 0);
      if (done4) seen = 1;
      else begin
        check_output("hold4", result4, held4);
        @(posedge clk); #1;
        edges++;
      end
    end
    check_output("latency4", edges, 4);
    check_output("busy4_cycles", busy_cycles, 4);
    held4 = e[3:0];
    @(posedge clk); #1;
    check_output("done4_pulse", done4, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start4 = 0; mode4 = 0; a4 = 0; b4 = 0;
    start8 = 0; mode8 = 0; a8 = 0; b8 = 0;
    held4 = 0;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_busy4", busy4, 0);
    check_output("rst_done4", done4, 0);
    check_output("rst_result4", {carry4, result4}, 0);
    check_output("rst_out8", {busy8, done8, carry8, result8}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    apply_stimulus(1'b0, 4'h7, 4'h9);
    apply_stimulus(1'b1, 4'h3, 4'h5);
    apply_stimulus(1'b1, 4'h9, 4'h9);

    // start re-asserted mid-operation and held: ignored until IDLE, accepted at T6
    mode4 = 0; a4 = 4'h2; b4 = 4'h3; start4 = 1'b1;
    q4.push_back({4'b0, model4(1'b0, 4'h2, 4'h3)});
    q4.push_back({4'b0, model4(1'b1, 4'hF, 4'hF)});
    @(posedge clk); #1;
    start4 = 1'b0;
    first_done = -1; second_done = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done4) begin
        if (first_done < 0) first_done = k;
        else begin
          second_done = k;
          start4 = 1'b0;
          break;
        end
      end
      if (k == 2) begin
        start4 = 1'b1; mode4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
      end
    end
    check_output("b2b_first_done_edge", first_done, 4);
    check_output("b2b_second_done_edge", second_done, 10);
    start4 = 1'b0;
    held4 = 4'h0;
    @(posedge clk); #1;

    apply_stimulus(1'b1, 4'h3, 4'h5);

    mode4 = 0; a4 = 4'h1; b4 = 4'h1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("midrst_busy", busy4, 0);
    check_output("midrst_done", done4, 0);
    check_output("midrst_result", {carry4, result4}, 0);
    held4 = 4'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    done_count = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done4) done_count++;
    end
    check_output("no_done_after_reset", done_count, 0);
    apply_stimulus(1'b0, 4'hA, 4'h3);

    for (int m = 0; m < 2; m++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          apply_stimulus(1'(m), 4'(x), 4'(y));

    mode8 = 0; a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
    q8.push_back({1'b1, 8'h00});
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    edges8 = 0;
    while (!done8 && edges8 < 24) begin
      @(posedge clk); #1;
      edges8++;
    end
    check_output("latency8", edges8, 8);
    @(posedge clk); #1;

    check_output("q4_drained", q4.size(), 0);
    check_output("q8_drained", q8.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
